// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the single write port of the buffer FIFO between NUM_REQ producers.
// A grant is handed out round-robin from rr_ptr. The granted producer streams
// beats over a valid/ready handshake until it marks last, exhausts MAX_BURST
// beats, or leaves valid low for IDLE_TO unstalled cycles. Accepted beats reach
// the FIFO one cycle later through registered write-enable and write-data.
// Writes are throttled on the FIFO's almost-full and full flags.

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BURST  = 8,
    parameter int IDLE_TO    = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_alm_full,
    output logic                          fifo_wren,
    output logic [DATA_WIDTH-1:0]         fifo_wrdata,
    output logic                          grant_vld,
    output logic [ID_W-1:0]               grant_id,
    output logic [31:0]                   beat_cnt
);

    // Arbiter states.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Successor of a requester index, wrapping at NUM_REQ (which need not
    // be a power of two).
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        nxt = (id == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (id + ID_W'(1));
        return nxt;
    endfunction

    // First valid requester searching upward from ptr, wrapping modulo
    // NUM_REQ. The scan runs from the farthest candidate to the nearest so
    // the last hit (the nearest one) wins without needing a found flag.
    // The result is only meaningful when at least one valid bit is set.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   sum;
        logic [ID_W:0]   idx;
        logic [ID_W-1:0] win;
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            idx = (sum >= (ID_W+1)'(NUM_REQ)) ? (sum - (ID_W+1)'(NUM_REQ)) : sum;
            win = valid[idx[ID_W-1:0]] ? idx[ID_W-1:0] : win;
        end
        return win;
    endfunction

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    logic [0:0]            state_q,     state_d;
    logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]       grant_id_q,  grant_id_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic [3:0]            idle_cnt_q,  idle_cnt_d;
    logic                  wren_q,      wren_d;
    logic [DATA_WIDTH-1:0] wrdata_q,    wrdata_d;
    logic [31:0]           beat_cnt_q,  beat_cnt_d;

    // Combinational helpers
    logic [DATA_WIDTH-1:0] beat_s [NUM_REQ];
    logic                  in_burst_s;
    logic                  stall_s;
    logic                  any_valid_s;
    logic                  gnt_valid_s;
    logic                  gnt_last_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;
    logic                  accept_s;
    logic                  burst_limit_s;
    logic                  idle_limit_s;
    logic [ID_W-1:0]       rr_winner_s;
    logic [NUM_REQ-1:0]    ready_s;

    // Unpack the flattened beat bus into one slot per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign beat_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_burst_s  = (state_q == ST_BURST);
    assign stall_s     = fifo_full | fifo_alm_full;
    assign any_valid_s = |req_valid;
    assign gnt_valid_s = req_valid[grant_id_q];
    assign gnt_last_s  = req_last[grant_id_q];
    assign gnt_data_s  = beat_s[grant_id_q];
    assign accept_s    = in_burst_s & gnt_valid_s & ~stall_s;
    assign rr_winner_s = rr_pick(req_valid, rr_ptr_q);

    // This beat is the one that fills the burst allowance.
    assign burst_limit_s = (burst_cnt_q == 8'(MAX_BURST - 1));
    // This is the last quiet cycle the granted requester is allowed.
    assign idle_limit_s  = (idle_cnt_q == 4'(IDLE_TO - 1));

    // Ready goes only to the granted requester, and only while the FIFO has room.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        if (in_burst_s && !stall_s) begin
            ready_s[grant_id_q] = 1'b1;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Grant FSM: pick a winner in IDLE, then hold it until last, burst
    // limit or idle timeout. Stalls freeze the idle counter.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s && !fifo_alm_full) begin
                    state_d     = ST_BURST;
                    grant_id_d  = rr_winner_s;
                    burst_cnt_d = 8'd0;
                    idle_cnt_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (accept_s) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    idle_cnt_d  = 4'd0;
                    if (gnt_last_s || burst_limit_s) begin
                        state_d     = ST_IDLE;
                        rr_ptr_d    = next_id(grant_id_q);
                        burst_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else if (gnt_valid_s) begin
                    // Valid but stalled by the FIFO: still an active requester.
                    idle_cnt_d = 4'd0;
                end else if (stall_s) begin
                    // FIFO stall: the quiet time does not count against the producer.
                    idle_cnt_d = idle_cnt_q;
                end else if (idle_limit_s) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = next_id(grant_id_q);
                    burst_cnt_d = 8'd0;
                    idle_cnt_d  = 4'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = 8'd0;
                idle_cnt_d  = 4'd0;
            end
        endcase
    end

    // Write path: an accepted beat is presented to the FIFO on the next cycle.
    always_comb begin
        wren_d     = accept_s;
        beat_cnt_d = beat_cnt_q + {31'd0, accept_s};
        if (accept_s) begin
            wrdata_d = gnt_data_s;
        end else begin
            wrdata_d = wrdata_q;
        end
    end

    // State registers with synchronous active-low reset; reset drops any burst in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {ID_W{1'b0}};
            grant_id_q  <= {ID_W{1'b0}};
            burst_cnt_q <= 8'd0;
            idle_cnt_q  <= 4'd0;
            wren_q      <= 1'b0;
            wrdata_q    <= {DATA_WIDTH{1'b0}};
            beat_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            wren_q      <= wren_d;
            wrdata_q    <= wrdata_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign req_ready   = ready_s;
    assign fifo_wren   = wren_q;
    assign fifo_wrdata = wrdata_q;
    assign grant_vld   = in_burst_s;
    assign grant_id    = grant_id_q;
    assign beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed scenarios followed by a randomized phase. Producers are modelled as
// per-requester beat counters. A transaction-level reference model tracks who
// owns the write port and which beats must reach the FIFO.

module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 128;
    localparam int MB  = 8;
    localparam int ITO = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_alm_full;
    logic            fifo_wren;
    logic [DW-1:0]   fifo_wrdata;
    logic            grant_vld;
    logic [1:0]      grant_id;
    logic [31:0]     beat_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TO(ITO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_alm_full(fifo_alm_full),
        .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
        .grant_vld(grant_vld), .grant_id(grant_id), .beat_cnt(beat_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Producer state: beats left in the current burst, last-marker usage,
    // voluntary pause, and the beat currently offered.
    int            rem      [N];
    bit            use_last [N];
    bit            pause    [N];
    logic [DW-1:0] cur      [N];

    // Reference model: owner of the write port (-1 = nobody), search pointer,
    // beats in this grant, quiet cycles, last granted id, and FIFO-side results.
    int            m_owner;
    int            m_ptr;
    int            m_beats;
    int            m_quiet;
    int            m_gid;
    bit            m_wr;
    logic [DW-1:0] m_wdata;
    logic [31:0]   m_total;

    function automatic logic [DW-1:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = (rem[i] > 0) && !pause[i];
            req_last[i]              = use_last[i] && (rem[i] == 1);
            req_data[i*DW +: DW]     = cur[i];
        end
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_owner >= 0 && !fifo_full && !fifo_alm_full) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic m_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    // One clock edge of the reference model, from the inputs present before it.
    task automatic model_step();
        bit stalled;
        if (!rstn) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_quiet = 0; m_gid = 0;
            m_wr = 1'b0; m_wdata = '0; m_total = 32'd0;
            return;
        end
        m_wr = 1'b0;
        if (m_owner < 0) begin
            if ((|req_valid) && !fifo_alm_full) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
                m_gid = m_owner; m_beats = 0; m_quiet = 0;
            end
        end else begin
            stalled = fifo_full || fifo_alm_full;
            if (req_valid[m_owner] && !stalled) begin
                m_wr = 1'b1;
                m_wdata = req_data[m_owner*DW +: DW];
                m_total = m_total + 32'd1;
                m_beats++;
                m_quiet = 0;
                if (req_last[m_owner] || m_beats == MB) m_release();
            end else if (req_valid[m_owner]) begin
                m_quiet = 0;
            end else if (!stalled) begin
                m_quiet++;
                if (m_quiet == ITO) m_release();
            end
        end
    endtask

    // Drive, check ready, step the model across one edge, check registered outputs.
    task automatic cycle();
        logic [N-1:0] hs;
        drive();
        #1;
        chk("req_ready", DW'(req_ready), DW'(model_ready()));
        hs = rstn ? (req_valid & req_ready) : '0;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                rem[i]--;
                cur[i] = rnd_beat();
            end
        end
        chk("fifo_wren",   DW'(fifo_wren),   DW'(m_wr));
        chk("fifo_wrdata", fifo_wrdata,      m_wdata);
        chk("grant_vld",   DW'(grant_vld),   DW'(m_owner >= 0));
        chk("grant_id",    DW'(grant_id),    DW'(m_gid));
        chk("beat_cnt",    DW'(beat_cnt),    DW'(m_total));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Advance until the model has counted 'target' beats, bounded.
    task automatic run_until_total(input int target, input string tag);
        int k;
        k = 0;
        while (int'(m_total) < target && k < 200) begin
            cycle();
            k++;
        end
        chk(tag, DW'(k >= 200), DW'(0));
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        run(n);
        rstn = 1'b1;
    endtask

    initial begin
        int base;
        rstn = 1'b0; fifo_full = 1'b0; fifo_alm_full = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; use_last[i] = 1'b0; pause[i] = 1'b0; cur[i] = rnd_beat();
        end
        drive();
        @(posedge clk);
        #1;
        model_step();

        // Reset state
        do_reset(2);
        chk("rst beat_cnt", DW'(beat_cnt), DW'(0));
        chk("rst grant_vld", DW'(grant_vld), DW'(0));
        chk("rst fifo_wren", DW'(fifo_wren), DW'(0));

        // Single requester: req1, 3 beats, last on the third
        rem[1] = 3; use_last[1] = 1'b1;
        cycle();
        chk("s1 grant_id", DW'(grant_id), DW'(1));
        run(8);
        chk("s1 beat_cnt", DW'(beat_cnt), DW'(3));
        chk("s1 idle", DW'(grant_vld), DW'(0));

        // Round-robin: four producers with 2-beat bursts
        for (int i = 0; i < N; i++) begin rem[i] = 2; use_last[i] = 1'b1; end
        run(20);
        chk("s2 beat_cnt", DW'(beat_cnt), DW'(11));

        // Burst limit: req2 streams 20 beats with no last marker
        rem[2] = 20; use_last[2] = 1'b0;
        run(35);
        chk("s3 beat_cnt", DW'(beat_cnt), DW'(31));

        // Backpressure: almost-full for 5 cycles after beat 3
        rem[1] = 8; use_last[1] = 1'b1;
        base = int'(m_total);
        run_until_total(base + 3, "s4 wait");
        fifo_alm_full = 1'b1;
        run(5);
        chk("s4 hold", DW'(grant_vld), DW'(1));
        fifo_alm_full = 1'b0;
        run(12);
        chk("s4 beat_cnt", DW'(beat_cnt), DW'(base + 8));

        // Reset mid-burst: req2, 5 beats, reset during beat 2
        rem[2] = 5; use_last[2] = 1'b1;
        base = int'(m_total);
        run_until_total(base + 1, "s5 wait");
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        chk("s5 wren", DW'(fifo_wren), DW'(0));
        chk("s5 beat_cnt", DW'(beat_cnt), DW'(0));
        rem[0] = 2; use_last[0] = 1'b1;
        cycle();
        chk("s5 regrant", DW'(grant_id), DW'(0));
        run(12);

        // Timeout: req0 goes quiet after one beat, req3 waiting
        do_reset(1);
        rem[0] = 5; use_last[0] = 1'b0;
        base = int'(m_total);
        run_until_total(base + 1, "s6 wait");
        pause[0] = 1'b1;
        rem[3] = 2; use_last[3] = 1'b1;
        run(4);
        chk("s6 timeout", DW'(grant_vld), DW'(0));
        cycle();
        chk("s6 next", DW'(grant_id), DW'(3));
        run(6);
        pause[0] = 1'b0;
        run(10);

        // Randomized phase
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 12);
                    use_last[i] = ($urandom_range(0, 1) == 1);
                end
                pause[i] = ($urandom_range(0, 6) == 0);
            end
            fifo_alm_full = ($urandom_range(0, 5) == 0);
            fifo_full = fifo_alm_full && ($urandom_range(0, 2) == 0);
            rstn = !($urandom_range(0, 249) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
